// File: rtl/spi_device.sv
// SPI mode-0 slave front end: synchronises raw SCK/CS/MOSI into clk, deserialises
// MOSI bytes with command flagging, and serialises reply bytes onto MISO.
module spi_device #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_clk_pin,
    input  logic       spi_cs_pin,
    input  logic       spi_mosi_pin,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       spi_cs,
    output logic [7:0] spi_rx_data,
    output logic       spi_rx_strobe,
    output logic       spi_rx_cmd,
    input  logic       spi_tx_strobe,
    input  logic [7:0] spi_tx_data,
    output logic       tx_underrun
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_prev;
    logic                   cs_prev;

    logic                   sck;
    logic                   mosi;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   cs_assert;
    logic                   cs_deassert;
    logic                   boundary_load;

    logic [2:0]             bit_count;
    logic [6:0]             rx_shift;
    logic [7:0]             rx_next;
    logic                   first_byte;

    logic [7:0]             tx_shift;
    logic [7:0]             tx_buf;
    logic                   tx_pending;
    logic                   tx_used;

    // Pin synchronisers; CS resets to the deasserted level so no false assert follows reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk_pin};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_pin};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_pin};
            sck_prev  <= sck_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck         = sck_sync[SYNC_STAGES-1];
    assign mosi        = mosi_sync[SYNC_STAGES-1];
    assign spi_cs      = cs_sync[SYNC_STAGES-1];
    assign spi_miso_oe = ~spi_cs;
    assign spi_miso    = tx_shift[7];

    assign cs_assert     = ~spi_cs & cs_prev;
    assign cs_deassert   = spi_cs & ~cs_prev;
    assign sck_rise      = sck & ~sck_prev & ~spi_cs;
    assign sck_fall      = ~sck & sck_prev & ~spi_cs;
    assign boundary_load = sck_fall & ~cs_assert & (bit_count == 3'd0);
    assign rx_next       = {rx_shift, mosi};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_count     <= 3'd0;
            rx_shift      <= 7'd0;
            spi_rx_data   <= 8'd0;
            spi_rx_strobe <= 1'b0;
            spi_rx_cmd    <= 1'b0;
            first_byte    <= 1'b1;
            tx_shift      <= IDLE_BYTE;
            tx_buf        <= 8'd0;
            tx_pending    <= 1'b0;
            tx_used       <= 1'b0;
            tx_underrun   <= 1'b0;
        end else begin
            spi_rx_strobe <= 1'b0;
            spi_rx_cmd    <= 1'b0;

            if (cs_deassert) begin
                // A partial byte is simply abandoned: no strobe, counter rewinds.
                bit_count   <= 3'd0;
                first_byte  <= 1'b1;
                tx_pending  <= 1'b0;
                tx_used     <= 1'b0;
                tx_underrun <= 1'b0;
            end else if (cs_assert) begin
                tx_shift   <= tx_pending ? tx_buf : IDLE_BYTE;
                tx_used    <= tx_pending;
                tx_pending <= 1'b0;
            end else begin
                if (sck_rise) begin
                    rx_shift  <= rx_next[6:0];
                    bit_count <= bit_count + 3'd1;
                    if (bit_count == 3'd7) begin
                        spi_rx_data   <= rx_next;
                        spi_rx_strobe <= 1'b1;
                        spi_rx_cmd    <= first_byte;
                        first_byte    <= 1'b0;
                    end
                end

                if (sck_fall) begin
                    if (bit_count == 3'd0) begin
                        // Byte boundary: a same-cycle strobe bypasses the buffer.
                        if (spi_tx_strobe) begin
                            tx_shift <= spi_tx_data;
                            tx_used  <= 1'b1;
                        end else if (tx_pending) begin
                            tx_shift <= tx_buf;
                            tx_used  <= 1'b1;
                        end else begin
                            tx_shift <= IDLE_BYTE;
                            if (tx_used) begin
                                tx_underrun <= 1'b1;
                            end
                        end
                        tx_pending <= 1'b0;
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b1};
                    end
                end
            end

            // Buffered reply; last strobe wins. Placed last so a new byte is never lost.
            if (spi_tx_strobe && !boundary_load) begin
                tx_buf     <= spi_tx_data;
                tx_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_device.sv
// Randomised scoreboard bench for spi_device: a bit-banged SPI master drives the
// pins while independent monitors compare received bytes and MISO bytes to a model.
module tb_spi_device;

    localparam int         SYNC_STAGES = 2;
    localparam logic [7:0] IDLE_BYTE   = 8'hFF;
    localparam int         HALF        = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_clk_pin = 1'b0;
    logic       spi_cs_pin = 1'b1;
    logic       spi_mosi_pin = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       spi_cs;
    logic [7:0] spi_rx_data;
    logic       spi_rx_strobe;
    logic       spi_rx_cmd;
    logic       spi_tx_strobe = 1'b0;
    logic [7:0] spi_tx_data = 8'd0;
    logic       tx_underrun;

    spi_device #(
        .SYNC_STAGES(SYNC_STAGES),
        .IDLE_BYTE  (IDLE_BYTE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spi_clk_pin  (spi_clk_pin),
        .spi_cs_pin   (spi_cs_pin),
        .spi_mosi_pin (spi_mosi_pin),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .spi_cs       (spi_cs),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_strobe(spi_rx_strobe),
        .spi_rx_cmd   (spi_rx_cmd),
        .spi_tx_strobe(spi_tx_strobe),
        .spi_tx_data  (spi_tx_data),
        .tx_underrun  (tx_underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       cmd;
    } rx_exp_t;

    rx_exp_t    rx_q[$];
    logic [7:0] miso_q[$];

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the reply path.
    logic       m_first;
    logic       m_pend;
    logic [7:0] m_reply;
    logic       m_used;
    logic       m_underrun;
    logic [7:0] m_loaded;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_first    = 1'b1;
        m_pend     = 1'b0;
        m_reply    = 8'd0;
        m_used     = 1'b0;
        m_underrun = 1'b0;
        m_loaded   = IDLE_BYTE;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic give_reply(input logic [7:0] r);
        spi_tx_strobe = 1'b1;
        spi_tx_data   = r;
        m_pend        = 1'b1;
        m_reply       = r;
        @(negedge clk);
        spi_tx_strobe = 1'b0;
    endtask

    // Shift nbits MSB-first; replies are offered during the last bit's high phase.
    task automatic shift_bits(input logic [7:0] b, input int nbits, input int nrep,
                              input logic [7:0] r0, input logic [7:0] r1);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi_pin = b[i];
            wait_clk(HALF);
            spi_clk_pin = 1'b1;
            if (i == 0 && nrep > 0) begin
                wait_clk(4);
                give_reply(r0);
                if (nrep > 1) give_reply(r1);
                wait_clk(HALF - 4 - nrep);
            end else begin
                wait_clk(HALF);
            end
            spi_clk_pin = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, input int nrep,
                            input logic [7:0] r0, input logic [7:0] r1);
        rx_q.push_back('{data: b, cmd: m_first});
        m_first = 1'b0;
        miso_q.push_back(m_loaded);
        shift_bits(b, 8, nrep, r0, r1);
        wait_clk(4);
        if (m_pend) begin
            m_loaded = m_reply;
            m_used   = 1'b1;
        end else begin
            m_loaded = IDLE_BYTE;
            if (m_used) m_underrun = 1'b1;
        end
        m_pend = 1'b0;
        check("tx_underrun_after_byte", tx_underrun, m_underrun);
    endtask

    task automatic cs_begin();
        spi_cs_pin = 1'b0;
        m_first    = 1'b1;
        m_loaded   = m_pend ? m_reply : IDLE_BYTE;
        m_used     = m_pend;
        m_pend     = 1'b0;
        wait_clk(HALF);
        check("spi_cs_asserted", spi_cs, 1'b0);
        check("spi_miso_oe_asserted", spi_miso_oe, 1'b1);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        spi_cs_pin = 1'b1;
        wait_clk(6);
        m_pend     = 1'b0;
        m_used     = 1'b0;
        m_underrun = 1'b0;
        check("spi_cs_deasserted", spi_cs, 1'b1);
        check("spi_miso_oe_deasserted", spi_miso_oe, 1'b0);
        check("tx_underrun_cleared", tx_underrun, m_underrun);
        wait_clk(4);
    endtask

    // Received-byte monitor.
    rx_exp_t rx_e;
    always @(negedge clk) begin
        if (spi_rx_strobe) begin
            check("rx_strobe_expected", rx_q.size() != 0, 1'b1);
            if (rx_q.size() != 0) begin
                rx_e = rx_q.pop_front();
                check("spi_rx_data", spi_rx_data, rx_e.data);
                check("spi_rx_cmd", spi_rx_cmd, rx_e.cmd);
            end
        end else if (spi_rx_cmd) begin
            check("cmd_without_strobe", spi_rx_cmd, 1'b0);
        end
    end

    // MISO monitor: assembles the byte seen by the master on rising SCK.
    int         m_bits = 0;
    logic [7:0] m_byte = 8'd0;
    initial begin
        forever begin
            @(posedge spi_clk_pin or posedge spi_cs_pin);
            if (spi_cs_pin) begin
                m_bits = 0;
            end else begin
                m_byte = {m_byte[6:0], spi_miso};
                m_bits++;
                if (m_bits == 8) begin
                    m_bits = 0;
                    check("miso_byte_expected", miso_q.size() != 0, 1'b1);
                    if (miso_q.size() != 0) check("miso_byte", m_byte, miso_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        wait_clk(4);
        check("reset_spi_cs", spi_cs, 1'b1);
        check("reset_spi_miso", spi_miso, 1'b1);
        check("reset_spi_miso_oe", spi_miso_oe, 1'b0);
        check("reset_rx_data", spi_rx_data, 8'd0);
        check("reset_rx_strobe", spi_rx_strobe, 1'b0);
        check("reset_tx_underrun", tx_underrun, 1'b0);
        reset = 1'b0;
        wait_clk(4);

        // Command plus three data bytes, then one reply and an underrun.
        cs_begin();
        spi_byte(8'h03, 0, 8'h00, 8'h00);
        spi_byte(8'h12, 0, 8'h00, 8'h00);
        spi_byte(8'h34, 0, 8'h00, 8'h00);
        spi_byte(8'h56, 1, 8'hA5, 8'h00);
        check("underrun_before_reply_byte", tx_underrun, 1'b0);
        spi_byte(8'h00, 0, 8'h00, 8'h00);
        spi_byte(8'h00, 0, 8'h00, 8'h00);
        check("underrun_after_idle", tx_underrun, 1'b1);
        cs_end();

        // Partial byte is discarded; the next full byte is a command again.
        cs_begin();
        shift_bits(8'hB7, 5, 0, 8'h00, 8'h00);
        cs_end();
        cs_begin();
        spi_byte(8'h9F, 2, 8'h11, 8'h22);
        spi_byte(8'h00, 0, 8'h00, 8'h00);
        cs_end();

        // Reset in the middle of a byte.
        cs_begin();
        spi_byte(8'h3C, 1, 8'h77, 8'h00);
        shift_bits(8'hE1, 3, 0, 8'h00, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_spi_cs", spi_cs, 1'b1);
        check("midreset_spi_miso", spi_miso, 1'b1);
        check("midreset_spi_miso_oe", spi_miso_oe, 1'b0);
        check("midreset_rx_data", spi_rx_data, 8'd0);
        check("midreset_rx_strobe", spi_rx_strobe, 1'b0);
        check("midreset_tx_underrun", tx_underrun, 1'b0);
        spi_cs_pin  = 1'b1;
        spi_clk_pin = 1'b0;
        wait_clk(4);
        reset = 1'b0;
        model_reset();
        wait_clk(4);
        cs_begin();
        spi_byte(8'h05, 0, 8'h00, 8'h00);
        cs_end();

        // Randomised transactions.
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(1, 0) == 1) give_reply(8'($urandom));
            wait_clk(2);
            cs_begin();
            for (int n = 0, len = $urandom_range(5, 1); n < len; n++) begin
                spi_byte(8'($urandom), $urandom_range(2, 0), 8'($urandom), 8'($urandom));
            end
            cs_end();
        end

        wait_clk(20);
        check("rx_queue_drained", rx_q.size(), 0);
        check("miso_queue_drained", miso_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
